// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - field layout helpers, decoded bundle type and NOP encoding for decode_stage
package decode_pkg;

    localparam int DEF_OP_W     = 4;
    localparam int DEF_RA_W     = 2;
    localparam int DEF_THREE_OP = 0;

    // The NOP is the all-zero instruction; its opcode field is therefore zero too.
    localparam logic [DEF_OP_W-1:0] NOP_OP = '0;

    function automatic int instr_width(input int op_w, input int ra_w, input int three_op);
        return op_w + ((three_op != 0) ? 3 : 2) * ra_w;
    endfunction

    function automatic int rd_lsb(input int op_w, input int ra_w, input int three_op);
        return instr_width(op_w, ra_w, three_op) - op_w - ra_w;
    endfunction

    function automatic int rs1_lsb(input int op_w, input int ra_w, input int three_op);
        return rd_lsb(op_w, ra_w, three_op) - ra_w;
    endfunction

    function automatic int rs2_lsb(input int op_w, input int ra_w, input int three_op);
        return rs1_lsb(op_w, ra_w, three_op) - ra_w;
    endfunction

    typedef struct packed {
        logic [DEF_OP_W-1:0] alu_op;
        logic [DEF_RA_W-1:0] rd;
        logic [DEF_RA_W-1:0] rs1;
        logic [DEF_RA_W-1:0] rs2;
        logic                reg_write;
    } decoded_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write bits with set-wins update and 3-port hazard lookup
module reg_scoreboard
    import decode_pkg::*;
#(
    parameter int RA_W     = DEF_RA_W,
    parameter int NUM_REGS = 2**RA_W
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [RA_W-1:0]     set_addr,
    input  logic                clr_en,
    input  logic [RA_W-1:0]     clr_addr,
    input  logic [RA_W-1:0]     look_a,
    input  logic [RA_W-1:0]     look_b,
    input  logic [RA_W-1:0]     look_c,
    output logic                hit,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // One-hot masks; clearing is applied first so a same-register set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    // Pending bits register.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end

    // Lookup reflects registered state only, so a writeback never bypasses into this cycle.
    always_comb begin
        hit = busy[look_a] | busy[look_b] | busy[look_c];
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with scoreboard stall; illegal-opcode trap under DECODE_ILLEGAL_TRAP_EN
module decode_stage
    import decode_pkg::*;
#(
    parameter  int OP_W     = DEF_OP_W,
    parameter  int RA_W     = DEF_RA_W,
    parameter  int THREE_OP = DEF_THREE_OP,
    parameter  int NUM_OPS  = 16,
    localparam int INSTR_W  = instr_width(OP_W, RA_W, THREE_OP),
    localparam int NUM_REGS = 2**RA_W
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_W-1:0]     alu_op,
    output logic [RA_W-1:0]     rd_addr,
    output logic [RA_W-1:0]     rs1_addr,
    output logic [RA_W-1:0]     rs2_addr,
    output logic                reg_write,
    input  logic                wb_valid,
    input  logic [RA_W-1:0]     wb_addr,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                illegal,
    output logic                illegal_seen,
`endif
    output logic [NUM_REGS-1:0] busy_regs
);

    localparam int RD_LSB  = rd_lsb(OP_W, RA_W, THREE_OP);
    localparam int RS1_LSB = rs1_lsb(OP_W, RA_W, THREE_OP);

    if (NUM_OPS < 1 || NUM_OPS > 2**OP_W) begin : g_bad_num_ops
        $error("decode_stage: NUM_OPS out of range for OP_W");
    end

    logic [OP_W-1:0] dec_op;
    logic [RA_W-1:0] dec_rd;
    logic [RA_W-1:0] dec_rs1;
    logic [RA_W-1:0] dec_rs2;
    logic            is_nop;
    logic            dec_illegal;
    logic            dec_write;
    logic            sb_hit;
    logic            hazard;
    logic            accept;

    assign dec_op  = instr[INSTR_W-1 -: OP_W];
    assign dec_rd  = instr[RD_LSB +: RA_W];
    assign dec_rs1 = instr[RS1_LSB +: RA_W];
    assign is_nop  = (instr == '0);

    if (THREE_OP != 0) begin : g_three_op
        assign dec_rs2 = instr[rs2_lsb(OP_W, RA_W, THREE_OP) +: RA_W];
    end else begin : g_two_op
        assign dec_rs2 = dec_rd;
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [OP_W:0] NUM_OPS_V = (OP_W+1)'(NUM_OPS);
    assign dec_illegal = ({1'b0, dec_op} >= NUM_OPS_V);
`else
    assign dec_illegal = 1'b0;
`endif

    // An illegal instruction still flows through but never claims a register.
    assign dec_write = !is_nop && !dec_illegal;
    assign hazard    = !is_nop && sb_hit;
    assign in_ready  = !rst && (!out_valid || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;

    reg_scoreboard #(.RA_W(RA_W), .NUM_REGS(NUM_REGS)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && dec_write),
        .set_addr (dec_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .look_a   (dec_rs1),
        .look_b   (dec_rs2),
        .look_c   (dec_rd),
        .hit      (sb_hit),
        .busy     (busy_regs)
    );

    // One-deep output register: load on accept, drop valid when drained, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            rd_addr   <= '0;
            rs1_addr  <= '0;
            rs2_addr  <= '0;
            reg_write <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op    <= dec_op;
            rd_addr   <= dec_rd;
            rs1_addr  <= dec_rs1;
            rs2_addr  <= dec_rs2;
            reg_write <= dec_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Illegal flag travels with the bundle; the sticky copy rises with it and clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal      <= 1'b0;
            illegal_seen <= 1'b0;
        end else if (accept) begin
            illegal      <= dec_illegal;
            illegal_seen <= illegal_seen | dec_illegal;
        end
    end
`endif

endmodule
